// File: rtl/uart_rx_oversampled.sv
// UART 8N1 receiver with 16x oversampling, mid-bit sampling, one-deep output register and framing/overrun flags.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_clk,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun,
  output logic            parity_err
);

  localparam int SW = $clog2((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nx;
  logic [SW-1:0]   s, s_nx;
  logic [NW-1:0]   n, n_nx;
  logic [DBIT-1:0] b, b_nx;
  logic            rx_sync1, rx_s;
  logic            s_clk_d;
  logic            tick;
  logic            armed, armed_nx;
  logic            done;
`ifdef UART_RX_PARITY_EN
  logic            p, p_nx;
`endif

  assign tick = s_clk & ~s_clk_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      s_clk_d  <= 1'b1;
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      b        <= '0;
      armed    <= 1'b1;
    end else begin
      rx_sync1 <= rx;
      rx_s     <= rx_sync1;
      s_clk_d  <= s_clk;
      state    <= state_nx;
      s        <= s_nx;
      n        <= n_nx;
      b        <= b_nx;
      armed    <= armed_nx;
    end
  end

  // armed drops at frame completion so a held-low line (break) cannot retrigger until rx_s has been seen high.
  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    b_nx     = b;
    armed_nx = armed;
    done     = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_nx     = p;
`endif
    case (state)
      IDLE: begin
        if (rx_s) begin
          armed_nx = 1'b1;
        end else if (armed) begin
          state_nx = START;
          s_nx     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == SW'(OVS/2 - 1)) begin
            s_nx = '0;
            if (!rx_s) begin
              state_nx = DATA;
              n_nx     = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_nx = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == SW'(OVS - 1)) begin
            b_nx = {rx_s, b[DBIT-1:1]};
            s_nx = '0;
            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              n_nx = n + 1'b1;
            end
          end else begin
            s_nx = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == SW'(OVS - 1)) begin
            p_nx     = rx_s;
            s_nx     = '0;
            state_nx = STOP;
          end else begin
            s_nx = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            done     = 1'b1;
            armed_nx = 1'b0;
            s_nx     = '0;
            state_nx = IDLE;
          end else begin
            s_nx = s + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A load coinciding with rd wins: the new byte stays valid and overrun is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_tick <= done;
      if (done) begin
        dout      <= b;
        rx_valid  <= 1'b1;
        frame_err <= ~rx_s;
        overrun   <= rx_valid & ~rd;
      end else if (rd && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p          <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      p <= p_nx;
      if (done) parity_err <= (^b) ^ p;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames are driven bit-by-bit on rx and completed bytes are
// checked against a scoreboard queue filled when each frame is sent.
module tb_uart_rx_oversampled;

  localparam int BIT_CLK = 128;
`ifdef UART_RX_PARITY_EN
  localparam int NDP = 9;
`else
  localparam int NDP = 8;
`endif
  // Frames start at a negedge where sdiv == 1, so the first tick lands on posedge 3 and
  // the final stop tick (tick index 8 + 16*NDP + 15) lands on a fixed posedge.
  localparam int DONE_EDGE = 3 + 8 * (8 + 16 * NDP + 15);
  localparam int FRAME_CLK = (NDP + 2) * BIT_CLK;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [2:0] sdiv = '0;
  logic       s_clk;
  logic [7:0] dout;
  logic       rx_valid, rx_done_tick, frame_err, overrun, parity_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) sdiv <= sdiv + 3'd1;
  assign s_clk = sdiv[2];

  uart_rx_oversampled #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_clk(s_clk), .rd(rd),
    .dout(dout), .rx_valid(rx_valid), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_done_tick === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_dout", dout, e.data);
        check("sb_frame_err", frame_err, e.ferr);
        check("sb_parity_err", parity_err, e.perr);
      end
    end
  end

  task automatic align();
    @(negedge clk);
    while (sdiv != 3'd1) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_v, input logic par_v,
                            input bit rd_at_done, input int abort_at);
    logic [10:0] bits;
    logic        perr;
    bit          aborted;
    aborted = 1'b0;
    if (NDP == 9) begin
      bits = {stop_v, par_v, data, 1'b0};
      perr = (^data) ^ par_v;
    end else begin
      bits = {1'b1, stop_v, data, 1'b0};
      perr = 1'b0;
    end
    if (abort_at < 0) sb.push_back('{data, ~stop_v, perr});
    align();
    for (int j = 0; j < FRAME_CLK; j++) begin
      if (j > 0) @(negedge clk);
      if (j == abort_at) begin
        aborted = 1'b1;
        break;
      end
      rx = bits[j / BIT_CLK];
      rd = (rd_at_done && j == DONE_EDGE);
    end
    if (!aborted) begin
      @(negedge clk);
      rx = 1'b1;
      rd = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (40) @(negedge clk);

    // Basic frame
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t1_count", done_count, 1);
    check("t1_dout", dout, 8'hA5);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_ferr", frame_err, 1'b0);
    check("t1_ovr", overrun, 1'b0);
    check("t1_done_low", rx_done_tick, 1'b0);

    // Short start glitch is rejected without touching outputs
    align();
    rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("t2_count", done_count, 1);
    check("t2_dout", dout, 8'hA5);
    check("t2_valid", rx_valid, 1'b1);
    check("t2_ferr", frame_err, 1'b0);
    check("t2_ovr", overrun, 1'b0);
    pulse_rd();
    check("rd_valid", rx_valid, 1'b0);
    check("rd_ovr", overrun, 1'b0);
    pulse_rd();
    check("rd_idle_valid", rx_valid, 1'b0);
    check("rd_idle_dout", dout, 8'hA5);

    // Framing error, then cleared by a good frame
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t3_count", done_count, 2);
    check("t3_dout", dout, 8'h3C);
    check("t3_ferr", frame_err, 1'b1);
    check("t3_valid", rx_valid, 1'b1);
    pulse_rd();
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t3b_count", done_count, 3);
    check("t3b_dout", dout, 8'h55);
    check("t3b_ferr", frame_err, 1'b0);
    check("t3b_ovr", overrun, 1'b0);

    // Overrun, cleared by rd; rd coinciding with completion
    pulse_rd();
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0, -1);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t4_count", done_count, 5);
    check("t4_dout", dout, 8'h22);
    check("t4_ovr", overrun, 1'b1);
    check("t4_valid", rx_valid, 1'b1);
    pulse_rd();
    check("t4_rd_valid", rx_valid, 1'b0);
    check("t4_rd_ovr", overrun, 1'b0);
    send_frame(8'h33, 1'b1, ^8'h33, 1'b0, -1);
    send_frame(8'h44, 1'b1, ^8'h44, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("t4s_count", done_count, 7);
    check("t4s_dout", dout, 8'h44);
    check("t4s_valid", rx_valid, 1'b1);
    check("t4s_ovr", overrun, 1'b0);

    // Reset in the middle of data bit 4
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 5 * BIT_CLK + 64);
    reset = 1'b0;
    #1;
    check("t5_dout", dout, 8'h00);
    check("t5_valid", rx_valid, 1'b0);
    check("t5_ferr", frame_err, 1'b0);
    check("t5_ovr", overrun, 1'b0);
    check("t5_done", rx_done_tick, 1'b0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t5b_count", done_count, 8);
    check("t5b_dout", dout, 8'h7E);
    check("t5b_valid", rx_valid, 1'b1);
    check("t5b_ferr", frame_err, 1'b0);
    check("t5b_ovr", overrun, 1'b0);

    // Break: one frame with framing error, no retrigger while held low
    pulse_rd();
    sb.push_back('{8'h00, 1'b1, 1'b0});
    align();
    rx = 1'b0;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("brk_count_low", done_count, 9);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("brk_count", done_count, 9);
    check("brk_dout", dout, 8'h00);
    check("brk_ferr", frame_err, 1'b1);
    send_frame(8'h96, 1'b1, ^8'h96, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("brk2_count", done_count, 10);
    check("brk2_dout", dout, 8'h96);
    check("brk2_ferr", frame_err, 1'b0);
    check("brk2_ovr", overrun, 1'b1);

`ifdef UART_RX_PARITY_EN
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t6_perr_ok", parity_err, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("t6_perr_bad", parity_err, 1'b1);
    check("t6_dout", dout, 8'h07);
`endif

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
